id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV32I instruction-decode stage. Sits between fetch and execute, directly upstream of the register file.
- Drives the register-file read addresses and gathers the operands. Forwards same-cycle writeback data and inserts a one-bubble load-use stall.
- Holds everything execute needs in an ID/EX pipeline register with a valid/ready handshake.

Parameters:
- N, 32, datapath / register width (operands, immediate, PC).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  N  PC of if_instr
- rf_read_add1  out  5  register-file read address 1 (rs1)
- rf_read_add2  out  5  register-file read address 2 (rs2)
- rf_read_data_1  in  N  register-file data for rf_read_add1, same cycle
- rf_read_data_2  in  N  register-file data for rf_read_add2, same cycle
- wb_write_en  in  1  writeback writes the register file this cycle
- wb_write_add  in  5  writeback destination
- wb_write_data  in  N  writeback data
- flush  in  1  branch/jump redirect from execute; kill the in-flight instruction
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  execute consumes the ID/EX register
- ex_pc  out  N  registered PC
- ex_rs1_data  out  N  registered operand 1
- ex_rs2_data  out  N  registered operand 2
- ex_imm  out  N  registered sign-extended immediate
- ex_rd  out  5  registered destination; 0 if the instruction does not write
- ex_funct3  out  3  registered funct3
- ex_funct7_b5  out  1  registered instr[30]
- ex_op_class  out  4  registered op_class_e
- ex_is_load  out  1  registered load flag

Behaviour:
- Reset (async, active-high):
  - ex_valid=0; all ex_* data outputs=0; ex_op_class=OP_NOP.
  - Internal load-pending flag (ld_pend)=0 and ld_rd=0.
- Read addresses:
  - rf_read_add1=if_instr[19:15], rf_read_add2=if_instr[24:20]. Both are combinational and driven regardless of if_valid.
- Operand select, per operand, in priority order:
  1. Address 0 → 0.
  2. wb_write_en && wb_write_add==address → wb_write_data (write-first bypass).
  3. Otherwise the register-file data.
- Immediate:
  - I, S, B, U and J formats, selected by opcode, each sign-extended to N.
  - R-type and illegal opcodes give 0.
- Destination:
  - ex_rd=instr[11:7] for writing classes: OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR.
  - ex_rd=0 for all other classes.
- Opcode classification:
  - An unknown opcode, or instr[1:0]!=2'b11, gives OP_ILLEGAL. It still propagates as valid so execute can raise the trap.
- Hazard:
  - hazard = if_valid && ld_pend && ld_rd!=0 && (rs1==ld_rd || rs2==ld_rd).
  - rs2 is compared only for classes that read rs2: OP, STORE, BRANCH.
  - rs1 is compared for all classes except LUI, AUIPC and JAL.
- Handshake:
  - if_ready = (!ex_valid || ex_ready) && !hazard && !flush.
  - fire = if_valid && if_ready. On fire, the ID/EX register loads and ex_valid<=1.
  - Else if ex_ready, ex_valid<=0. This is how a bubble appears during a hazard.
  - Else the register holds. Data outputs are stable while ex_valid && !ex_ready.
- Load tracking:
  - On fire of a LOAD with rd!=0: ld_pend<=1, ld_rd<=rd.
  - Otherwise, at any edge with ex_ready=1 and no such fire: ld_pend<=0.
  - Result: exactly one bubble when the dependent instruction follows directly.
- Flush:
  - At the edge: ex_valid<=0 and ld_pend<=0. Data registers may hold stale values.
  - if_ready=0 during the flush cycle, so the fetch instruction is dropped.
  - Flush has priority over fire and hazard.
- No combinational path from ex_ready to any ex_* output.
- Reset mid-stall clears everything; the first post-reset instruction is accepted immediately if valid.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams (OPC_LOAD=7'h03, OPC_OP_IMM=7'h13, OPC_AUIPC=7'h17, OPC_STORE=7'h23, OPC_OP=7'h33, OPC_LUI=7'h37, OPC_BRANCH=7'h63, OPC_JALR=7'h67, OPC_JAL=7'h6F, OPC_SYSTEM=7'h73)
  - op_class_e (4-bit): OP_NOP, OP_ALU, OP_ALU_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_ILLEGAL
  - imm_type_e: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
- Sub-module imm_gen: purely combinational; maps instr and imm_type to an N-bit immediate.

Test Plan:
- Reset, then if_valid=1 with ADDI x5,x0,-1 (0xFFF00293) → next cycle: ex_valid=1, ex_imm=0xFFFFFFFF, ex_rd=5, ex_rs1_data=0, ex_op_class=OP_ALU_IMM.
- rf_read_data_1=0x11 for x3, plus same-cycle wb write x3=0x22, with ADD x1,x3,x3 → ex_rs1_data=ex_rs2_data=0x22. Repeat with wb_write_add=0 and read x0 → operands 0.
- LW x7,0(x2), then ADD x8,x7,x1 back-to-back with ex_ready=1 → if_ready=0 for one cycle; one bubble (ex_valid=0); ADD issues the following cycle. ADD x8,x6,x1 instead → no bubble.
- ex_ready=0 for 3 cycles while ex_valid=1 → if_ready=0 and ex_* outputs unchanged; on release, the next instruction loads on the first ready edge.
- flush=1 while ex_valid=1 and if_valid=1 → ex_valid=0 next cycle, instruction dropped; a pending load-use stall is cancelled.
- Opcode 7'h0B, and instr[1:0]=2'b00 → ex_valid=1, ex_op_class=OP_ILLEGAL, ex_rd=0, ex_imm=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I decode definitions shared by the ID stage: opcodes, operation classes,
// immediate formats and the opcode classifier.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_ALU_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef struct packed {
    op_class_e op_class;
    imm_type_e imm_type;
    logic      writes_rd;
    logic      reads_rs1;
    logic      reads_rs2;
  } dec_t;

  // Anything without instr[1:0]==2'b11 falls through to OP_ILLEGAL.
  function automatic dec_t decode(input logic [6:0] opcode);
    dec_t d;
    d.op_class = OP_ILLEGAL;
    d.imm_type = IMM_NONE;
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD:   begin d.op_class = OP_LOAD;    d.imm_type = IMM_I; end
        OPC_OP_IMM: begin d.op_class = OP_ALU_IMM; d.imm_type = IMM_I; end
        OPC_AUIPC:  begin d.op_class = OP_AUIPC;   d.imm_type = IMM_U; end
        OPC_STORE:  begin d.op_class = OP_STORE;   d.imm_type = IMM_S; end
        OPC_OP:     begin d.op_class = OP_ALU;     d.imm_type = IMM_NONE; end
        OPC_LUI:    begin d.op_class = OP_LUI;     d.imm_type = IMM_U; end
        OPC_BRANCH: begin d.op_class = OP_BRANCH;  d.imm_type = IMM_B; end
        OPC_JALR:   begin d.op_class = OP_JALR;    d.imm_type = IMM_I; end
        OPC_JAL:    begin d.op_class = OP_JAL;     d.imm_type = IMM_J; end
        OPC_SYSTEM: begin d.op_class = OP_SYSTEM;  d.imm_type = IMM_I; end
        default:    begin d.op_class = OP_ILLEGAL; d.imm_type = IMM_NONE; end
      endcase
    end
    d.writes_rd = d.op_class inside {OP_ALU, OP_ALU_IMM, OP_LOAD, OP_LUI,
                                     OP_AUIPC, OP_JAL, OP_JALR};
    d.reads_rs1 = !(d.op_class inside {OP_LUI, OP_AUIPC, OP_JAL});
    d.reads_rs2 = d.op_class inside {OP_ALU, OP_STORE, OP_BRANCH};
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: reassembles and sign-extends the
// immediate field for the selected format.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [31:7]  instr,
  input  imm_type_e    imm_type,
  output logic [N-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = N'($signed(instr[31:20]));
      IMM_S:   imm = N'($signed({instr[31:25], instr[11:7]}));
      IMM_B:   imm = N'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:   imm = N'($signed({instr[31:12], 12'h000}));
      IMM_J:   imm = N'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file read, writeback bypass, one-bubble
// load-use interlock and the ID/EX pipeline register with valid/ready.
module id_stage
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_valid,
  output logic         if_ready,
  input  logic [31:0]  if_instr,
  input  logic [N-1:0] if_pc,
  output logic [4:0]   rf_read_add1,
  output logic [4:0]   rf_read_add2,
  input  logic [N-1:0] rf_read_data_1,
  input  logic [N-1:0] rf_read_data_2,
  input  logic         wb_write_en,
  input  logic [4:0]   wb_write_add,
  input  logic [N-1:0] wb_write_data,
  input  logic         flush,
  output logic         ex_valid,
  input  logic         ex_ready,
  output logic [N-1:0] ex_pc,
  output logic [N-1:0] ex_rs1_data,
  output logic [N-1:0] ex_rs2_data,
  output logic [N-1:0] ex_imm,
  output logic [4:0]   ex_rd,
  output logic [2:0]   ex_funct3,
  output logic         ex_funct7_b5,
  output op_class_e    ex_op_class,
  output logic         ex_is_load
);

  dec_t         dec;
  logic [4:0]   rs1, rs2, rd;
  logic [N-1:0] imm, op1, op2;
  logic         ld_pend;
  logic [4:0]   ld_rd;
  logic         hazard, fire, is_load;

  // Write-first bypass: a same-cycle writeback beats the register file.
  function automatic logic [N-1:0] sel_operand(input logic [4:0] a,
                                               input logic [N-1:0] rf);
    if (a == 5'd0)
      return '0;
    else if (wb_write_en && wb_write_add == a)
      return wb_write_data;
    else
      return rf;
  endfunction

  assign dec          = decode(if_instr[6:0]);
  assign rs1          = if_instr[19:15];
  assign rs2          = if_instr[24:20];
  assign rd           = dec.writes_rd ? if_instr[11:7] : 5'd0;
  assign is_load      = dec.op_class == OP_LOAD;
  assign rf_read_add1 = rs1;
  assign rf_read_add2 = rs2;
  assign op1          = sel_operand(rs1, rf_read_data_1);
  assign op2          = sel_operand(rs2, rf_read_data_2);

  imm_gen #(.N(N)) u_imm_gen (
    .instr    (if_instr[31:7]),
    .imm_type (dec.imm_type),
    .imm      (imm)
  );

  // Only the source fields the class actually reads can create a stall.
  assign hazard = if_valid && ld_pend && (ld_rd != 5'd0) &&
                  ((dec.reads_rs1 && rs1 == ld_rd) ||
                   (dec.reads_rs2 && rs2 == ld_rd));

  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign fire     = if_valid && if_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ld_pend  <= 1'b0;
      ld_rd    <= 5'd0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ld_pend  <= 1'b0;
    end else begin
      if (fire)
        ex_valid <= 1'b1;
      else if (ex_ready)
        ex_valid <= 1'b0;
      // The load result becomes bypassable once execute has moved it on.
      if (fire && is_load && rd != 5'd0) begin
        ld_pend <= 1'b1;
        ld_rd   <= rd;
      end else if (ex_ready) begin
        ld_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_funct7_b5 <= 1'b0;
      ex_op_class  <= OP_NOP;
      ex_is_load   <= 1'b0;
    end else if (fire) begin
      ex_pc        <= if_pc;
      ex_rs1_data  <= op1;
      ex_rs2_data  <= op2;
      ex_imm       <= imm;
      ex_rd        <= rd;
      ex_funct3    <= if_instr[14:12];
      ex_funct7_b5 <= if_instr[30];
      ex_op_class  <= dec.op_class;
      ex_is_load   <= is_load;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural decode model.
module tb_id_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_read_add1, rf_read_add2;
  logic [31:0] rf_read_data_1, rf_read_data_2;
  logic        wb_write_en;
  logic [4:0]  wb_write_add;
  logic [31:0] wb_write_data;
  logic        flush, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7_b5;
  op_class_e   ex_op_class;
  logic        ex_is_load;

  always #5 clk = ~clk;

  id_stage #(.N(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_read_add1(rf_read_add1), .rf_read_add2(rf_read_add2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_write_en(wb_write_en), .wb_write_add(wb_write_add), .wb_write_data(wb_write_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5), .ex_op_class(ex_op_class), .ex_is_load(ex_is_load)
  );

  int vectors = 0;
  int errors  = 0;

  // Expected ID/EX contents plus the load that may still be in flight.
  logic        m_valid, m_clean, m_ldp, m_isld;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd, m_ldrd;
  logic [2:0]  m_f3;
  logic        m_f7;
  op_class_e   m_cls;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic op_class_e cls_of(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return OP_ILLEGAL;
    case (ins[6:0])
      7'h03: return OP_LOAD;
      7'h13: return OP_ALU_IMM;
      7'h17: return OP_AUIPC;
      7'h23: return OP_STORE;
      7'h33: return OP_ALU;
      7'h37: return OP_LUI;
      7'h63: return OP_BRANCH;
      7'h67: return OP_JALR;
      7'h6F: return OP_JAL;
      7'h73: return OP_SYSTEM;
      default: return OP_ILLEGAL;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    case (cls_of(ins))
      OP_LOAD, OP_ALU_IMM, OP_JALR, OP_SYSTEM: return 32'($signed(ins[31:20]));
      OP_STORE:  return 32'($signed({ins[31:25], ins[11:7]}));
      OP_BRANCH: return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      OP_LUI, OP_AUIPC: return {ins[31:12], 12'h000};
      OP_JAL:    return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ins);
    op_class_e c = cls_of(ins);
    if (c inside {OP_ALU, OP_ALU_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
      return ins[11:7];
    return 5'd0;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'h0;
    if (wb_write_en && wb_write_add == a) return wb_write_data;
    return rf;
  endfunction

  function automatic logic exp_ready();
    op_class_e c = cls_of(if_instr);
    logic u1 = !(c inside {OP_LUI, OP_AUIPC, OP_JAL}) && if_instr[19:15] == m_ldrd;
    logic u2 = (c inside {OP_ALU, OP_STORE, OP_BRANCH}) && if_instr[24:20] == m_ldrd;
    logic haz = if_valid && m_ldp && m_ldrd != 0 && (u1 || u2);
    return (!m_valid || ex_ready) && !haz && !flush;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_clean = 1; m_ldp = 0; m_ldrd = 0;
    m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    m_f3 = 0; m_f7 = 0; m_cls = OP_NOP; m_isld = 0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    logic rdy, fire;
    logic [31:0] ins;
    if (reset) model_reset();
    #1;
    rdy = exp_ready();
    chk("if_ready", {31'b0, if_ready}, {31'b0, rdy});
    chk("rf_read_add1", {27'b0, rf_read_add1}, {27'b0, if_instr[19:15]});
    chk("rf_read_add2", {27'b0, rf_read_add2}, {27'b0, if_instr[24:20]});
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    if (m_valid || m_clean) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs1_data", ex_rs1_data, m_rs1);
      chk("ex_rs2_data", ex_rs2_data, m_rs2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
      chk("ex_funct3", {29'b0, ex_funct3}, {29'b0, m_f3});
      chk("ex_funct7_b5", {31'b0, ex_funct7_b5}, {31'b0, m_f7});
      chk("ex_op_class", {28'b0, ex_op_class}, {28'b0, m_cls});
      chk("ex_is_load", {31'b0, ex_is_load}, {31'b0, m_isld});
    end
    fire = if_valid && rdy;
    ins  = if_instr;
    @(posedge clk);
    if (reset) model_reset();
    else if (flush) begin
      m_valid = 0; m_ldp = 0; m_clean = 0;
    end else begin
      if (fire) begin
        m_valid = 1; m_clean = 0;
        m_pc  = if_pc;
        m_rs1 = opnd(ins[19:15], rf_read_data_1);
        m_rs2 = opnd(ins[24:20], rf_read_data_2);
        m_imm = imm_of(ins);
        m_rd  = rd_of(ins);
        m_f3  = ins[14:12];
        m_f7  = ins[30];
        m_cls = cls_of(ins);
        m_isld = cls_of(ins) == OP_LOAD;
      end else if (ex_ready) m_valid = 0;
      if (fire && cls_of(ins) == OP_LOAD && rd_of(ins) != 0) begin
        m_ldp = 1; m_ldrd = rd_of(ins);
      end else if (ex_ready) m_ldp = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                             7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B};
    logic [31:0] ins = $urandom;
    int k = $urandom_range(0, 15);
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    if (k < 11) ins[6:0] = ops[k];
    else if (k < 15) ins[6:0] = 7'h03;
    return ins;
  endfunction

  localparam logic [31:0] ADDI_M1 = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] ADD_133 = 32'h003180B3; // add x1,x3,x3
  localparam logic [31:0] ADD_100 = 32'h000000B3; // add x1,x0,x0
  localparam logic [31:0] LW_72   = 32'h00012383; // lw x7,0(x2)
  localparam logic [31:0] ADD_DEP = 32'h00138433; // add x8,x7,x1
  localparam logic [31:0] ADD_IND = 32'h00130433; // add x8,x6,x1

  initial begin
    reset = 1; if_valid = 0; if_instr = 0; if_pc = 0; rf_read_data_1 = 0;
    rf_read_data_2 = 0; wb_write_en = 0; wb_write_add = 0; wb_write_data = 0;
    flush = 0; ex_ready = 0;
    model_reset();
    cycle(); cycle();
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_imm", ex_imm, 32'h0);
    chk("rst_class", {28'b0, ex_op_class}, {28'b0, OP_NOP});

    reset = 0; ex_ready = 1; if_valid = 1; if_instr = ADDI_M1; if_pc = 32'h100;
    cycle();
    chk("addi_valid", {31'b0, ex_valid}, 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
    chk("addi_rd", {27'b0, ex_rd}, 32'd5);
    chk("addi_rs1", ex_rs1_data, 32'h0);
    chk("addi_class", {28'b0, ex_op_class}, {28'b0, OP_ALU_IMM});

    if_instr = ADD_133; rf_read_data_1 = 32'h11; rf_read_data_2 = 32'h11;
    wb_write_en = 1; wb_write_add = 3; wb_write_data = 32'h22;
    cycle();
    chk("byp_rs1", ex_rs1_data, 32'h22);
    chk("byp_rs2", ex_rs2_data, 32'h22);
    if_instr = ADD_100; wb_write_add = 0;
    cycle();
    chk("x0_rs1", ex_rs1_data, 32'h0);
    chk("x0_rs2", ex_rs2_data, 32'h0);
    wb_write_en = 0;

    if_instr = LW_72; cycle();
    if_instr = ADD_DEP; #1 chk("lu_stall", {31'b0, if_ready}, 32'd0);
    cycle();
    chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
    cycle();
    chk("lu_issue", {31'b0, ex_valid}, 32'd1);
    chk("lu_rd", {27'b0, ex_rd}, 32'd8);
    if_instr = LW_72; cycle();
    if_instr = ADD_IND; #1 chk("lu_nodep", {31'b0, if_ready}, 32'd1);
    cycle();
    chk("nodep_valid", {31'b0, ex_valid}, 32'd1);

    if_instr = ADDI_M1; if_pc = 32'h200; cycle();
    ex_ready = 0; if_pc = 32'h204; if_instr = ADD_IND;
    repeat (3) begin
      #1 chk("bp_ready", {31'b0, if_ready}, 32'd0);
      cycle();
      chk("bp_pc", ex_pc, 32'h200);
    end
    ex_ready = 1; cycle();
    chk("bp_load", ex_pc, 32'h204);

    flush = 1; cycle();
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    flush = 0; if_instr = LW_72; cycle();
    flush = 1; if_instr = ADD_DEP; cycle();
    flush = 0; #1 chk("fl_cancel", {31'b0, if_ready}, 32'd1);
    cycle();

    if_instr = 32'h0012858B; cycle();
    chk("ill_class", {28'b0, ex_op_class}, {28'b0, OP_ILLEGAL});
    chk("ill_rd", {27'b0, ex_rd}, 32'd0);
    chk("ill_imm", ex_imm, 32'h0);
    if_instr = 32'hFFF00290; cycle();
    chk("ill2_valid", {31'b0, ex_valid}, 32'd1);
    chk("ill2_class", {28'b0, ex_op_class}, {28'b0, OP_ILLEGAL});
    chk("ill2_imm", ex_imm, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      if_valid       = ($urandom_range(0, 4) != 0);
      ex_ready       = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      if_instr       = rand_instr();
      if_pc          = $urandom;
      rf_read_data_1 = $urandom;
      rf_read_data_2 = $urandom;
      wb_write_en    = $urandom_range(0, 1) == 1;
      wb_write_add   = 5'($urandom_range(0, 7));
      wb_write_data  = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
